lfsr_rr_sched: RTL
==================

// Module: lfsr_rr_sched
// PURPOSE
// - Round-robin scheduler sharing one 4-bit LFSR datapath (reset/mod/lfsr_q) between two requesters.
// - Per grant: applies requester's tap mode, reseeds LFSR, streams N nibbles over a valid/ready port, pulses done.
// - Sits between user logic (ui_in-driven requests) and the LFSR instance; the LFSR gets lfsr_rst/lfsr_mod/lfsr_step only from here.
// PARAMETERS
// - NREQ     2  number of requesters (fixed; RTL supports 2 only)
// - LEN_W    4  burst-length field width; 0 encodes 2**LEN_W words
// PORTS
// - clk        in   1  system clock
// - rst_n      in   1  asynchronous active-low reset
// - req        in   2  request per requester; held high until done or abandoned
// - req_mod0   in   3  tap mode for requester 0
// - req_mod1   in   3  tap mode for requester 1
// - req_len0   in   4  burst length, requester 0 (0 = 16)
// - req_len1   in   4  burst length, requester 1 (0 = 16)
// - gnt        out  2  one-hot grant, held for whole burst
// - done       out  2  one-cycle pulse on last accepted word of grantee
// - lfsr_rst   out  1  active-high seed pulse to LFSR datapath
// - lfsr_mod   out  3  tap mode to LFSR datapath, stable while gnt!=0
// - lfsr_step  out  1  advance LFSR one state (combinational: rnd_valid & rnd_ready)
// - lfsr_q     in   4  current LFSR state from datapath
// - rnd_valid  out  1  rnd_data valid
// - rnd_ready  in   1  consumer accepts rnd_data
// - rnd_data   out  4  random nibble (= lfsr_q)
// - rnd_id     out  1  index of requester owning rnd_data
// BEHAVIOUR
// - Reset: state IDLE; gnt, done, lfsr_rst, lfsr_mod, rnd_valid, rnd_id, count = 0; rr pointer favours req0 first.
// - FSM IDLE -> SEED -> STREAM -> IDLE.
// - IDLE: if any req, grant per rr (both high -> requester != last served); latch mod/len; gnt set next cycle; -> SEED.
// - SEED (1 cycle): lfsr_rst=1, lfsr_mod=latched mode; -> STREAM.
// - STREAM: rnd_valid=1, rnd_data=lfsr_q, rnd_id=grantee; handshake when valid&ready -> lfsr_step=1, count-1.
// - Words stall indefinitely while rnd_ready=0; lfsr_step never asserts without handshake.
// - Last handshake (count==1): done[grantee] pulses that cycle's next edge; gnt clears; rr pointer = grantee; -> IDLE.
// - Grant latency: req high in IDLE -> gnt 1 cycle later, first rnd_valid 2 cycles later. Min 1 idle cycle between bursts.
// - len 0 -> 16 words; count is LEN_W+1 bits, no wrap.
// - Grantee drops req in STREAM: rnd_valid forced 0 that cycle, no step, no done; -> IDLE; rr pointer = grantee.
// - req/mod/len changes during a grant ignored (latched). Non-grantee req held pending, served next.
// - rst_n low mid-burst: everything returns to reset values immediately; no done.
// CONFIGURATION
// - LFSR_LOCKUP_CHK_EN defined: adds output lockup_cnt[3:0] (saturating at 15, reset 0).
//   In STREAM, lfsr_q==4'h0 -> rnd_valid=0, lockup_cnt+1, -> SEED (reseed); count unchanged.
// - Undefined: no lockup_cnt port; all-zero state streamed like any other value.
// TESTING
// - req=01, len0=3, mod0=5, ready=1 -> gnt=01 @+1, lfsr_rst @+1, 3 beats, rnd_id=0, done=01 on 3rd; lfsr_mod=5 throughout.
// - req=11 from reset, len=2 each -> req0 burst, done=01, IDLE cycle, req1 burst, done=10; next tie goes to req0.
// - len1=0, ready toggling 1/0 -> exactly 16 handshakes, 16 lfsr_step pulses, none while ready=0.
// - Grantee drops req after 1 of 4 words -> rnd_valid=0 same cycle, no done, pending requester granted next.
// - rst_n low mid-STREAM -> gnt=0, rnd_valid=0, lfsr_rst=0 asynchronously; post-reset req0 wins tie.
// - LFSR_LOCKUP_CHK_EN: force lfsr_q=0 in STREAM -> no beat, lockup_cnt=1, lfsr_rst pulse, burst resumes with count kept.

Source files
------------

// File: rtl/lfsr_rr_sched.sv
// rtl/lfsr_rr_sched.sv - two-requester round-robin scheduler for a shared 4-bit LFSR datapath
//
// Purpose:
//   Grants one of two requesters at a time. For each grant it applies the
//   requester's tap mode, reseeds the LFSR, streams N nibbles over a
//   valid/ready port and pulses done for the grantee.
//   FSM: IDLE -> SEED -> STREAM -> IDLE.
//
// Optional feature (macro LFSR_LOCKUP_CHK_EN):
//   Adds output lockup_cnt[3:0]. An all-zero LFSR state seen in STREAM is not
//   streamed; the LFSR is reseeded and the burst resumes with its count kept.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req[1:0]              request per requester, held until done or abandoned
//   req_mod0/1[2:0]       tap mode per requester
//   req_len0/1[3:0]       burst length per requester (0 = 16 words)
//   gnt[1:0]              one-hot grant, held for the whole burst
//   done[1:0]             one-cycle pulse after the grantee's last accepted word
//   lfsr_rst              active-high seed pulse to the LFSR
//   lfsr_mod[2:0]         tap mode to the LFSR
//   lfsr_step             advance the LFSR (valid & ready)
//   lfsr_q[3:0]           current LFSR state
//   rnd_valid/rnd_ready   stream handshake
//   rnd_data[3:0]         random nibble (= lfsr_q)
//   rnd_id                requester owning rnd_data
//   lockup_cnt[3:0]       saturating all-zero-state counter (LFSR_LOCKUP_CHK_EN only)

module lfsr_rr_sched #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2:0]        req_mod0,
  input  logic [2:0]        req_mod1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              lfsr_rst,
  output logic [2:0]        lfsr_mod,
  output logic              lfsr_step,
  input  logic [3:0]        lfsr_q,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [3:0]        rnd_data,
  output logic              rnd_id
`ifdef LFSR_LOCKUP_CHK_EN
  ,
  output logic [3:0]        lockup_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEED   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [LEN_W:0] C_ONE = {{LEN_W{1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [2:0]       r_mod;
  logic [LEN_W:0]   r_count;
  logic             r_id;
  logic             r_last;   // last requester served; reset to 1 so req0 wins the first tie

  logic [NREQ-1:0]  w_avail;
  logic             w_pick;
  logic [2:0]       w_sel_mod;
  logic [LEN_W-1:0] w_sel_len;
  logic [LEN_W:0]   w_sel_words;
  logic             w_stream;
  logic             w_owner_req;
  logic             w_lockup;
  logic             w_hs;
  logic             w_last;

  // A requester whose done is pulsing this cycle may still be holding req
  // while it reacts; masking it stops an immediate re-grant of the same burst.
  assign w_avail = req & ~r_done;

  always_comb begin
    w_pick = 1'b0;
    if (w_avail == 2'b11)
      w_pick = ~r_last;
    else if (w_avail[1] && !w_avail[0])
      w_pick = 1'b1;
  end

  assign w_sel_mod   = w_pick ? req_mod1 : req_mod0;
  assign w_sel_len   = w_pick ? req_len1 : req_len0;
  // Length 0 encodes 2**LEN_W words; the extra count bit avoids wrap.
  assign w_sel_words = (w_sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_sel_len};

  assign w_stream    = (r_state == S_STREAM);
  assign w_owner_req = req[r_id];

`ifdef LFSR_LOCKUP_CHK_EN
  assign w_lockup = w_stream & w_owner_req & (lfsr_q == 4'h0);
`else
  assign w_lockup = 1'b0;
`endif

  assign rnd_valid = w_stream & w_owner_req & ~w_lockup;
  assign w_hs      = rnd_valid & rnd_ready;
  assign w_last    = w_hs & (r_count == C_ONE);

  assign lfsr_step = w_hs;
  assign lfsr_rst  = (r_state == S_SEED);
  assign lfsr_mod  = r_mod;
  assign rnd_data  = lfsr_q;
  assign rnd_id    = r_id;
  assign gnt       = r_gnt;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_mod   <= '0;
      r_count <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_avail) begin
            r_state <= S_SEED;
            r_gnt   <= {w_pick, ~w_pick};
            r_id    <= w_pick;
            r_mod   <= w_sel_mod;
            r_count <= w_sel_words;
          end
        end
        S_SEED: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (!w_owner_req) begin
            // Abandoned burst: release without done.
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= r_id;
          end else if (w_lockup) begin
            r_state <= S_SEED;
          end else if (w_hs) begin
            r_count <= r_count - C_ONE;
            if (w_last) begin
              r_state        <= S_IDLE;
              r_gnt          <= '0;
              r_done[r_id]   <= 1'b1;
              r_last         <= r_id;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LFSR_LOCKUP_CHK_EN
  logic [3:0] r_lockup_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lockup_cnt <= 4'h0;
    else if (w_lockup && r_lockup_cnt != 4'hF)
      r_lockup_cnt <= r_lockup_cnt + 4'h1;
  end

  assign lockup_cnt = r_lockup_cnt;
`endif

endmodule
